// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter: access-size encodings,
// sequencer state enum, byte-lane mask constants and lane helper functions.
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE     = 2'b00;
  localparam size_t SZ_HALF     = 2'b01;
  localparam size_t SZ_WORD     = 2'b10;
  localparam size_t SZ_WORD_ALT = 2'b11;  // decoded exactly like SZ_WORD

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B0   = 4'b0001;
  localparam logic [3:0] MASK_H_LO = 4'b0011;
  localparam logic [3:0] MASK_H_HI = 4'b1100;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Byte-lane mask for an access; low address bits below the access size are ignored.
  function automatic logic [3:0] lane_mask(input size_t size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = MASK_B0 << lane;
      SZ_HALF: m = lane[1] ? MASK_H_HI : MASK_H_LO;
      default: m = MASK_WORD;
    endcase
    return m;
  endfunction

  // True when the address is not naturally aligned for the access size.
  function automatic logic misaligned(input size_t size, input logic [1:0] lane);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = lane[0];
      default: r = (lane != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// One requester port of the data-memory arbiter: request handshake plus the
// one-cycle response pulse.
//   valid/ready      request handshake (ready driven by arbiter)
//   we, adr, wdata   store flag, byte address, right-justified store data
//   size, is_unsigned access size and load extension mode
//   rsp_valid        one-cycle response pulse (no backpressure)
//   rsp_rdata        extended load data, 0 for stores
//   rsp_err          misaligned-access flag
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdata;
  size_t         size;
  logic          is_unsigned;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output valid, we, adr, wdata, size, is_unsigned,
    input  ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  valid, we, adr, wdata, size, is_unsigned,
    output ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane steering for a 4-lane, 32-bit memory.
//   st_size, st_lane, st_wdata -> st_data : right-justified store data moved
//                                           onto its byte lanes
//   ld_size, ld_lane, ld_unsigned, ld_word -> ld_data : lane extracted from
//                                           the memory word and extended
// Half accesses use lane[1] only; word accesses ignore the lane.
// -----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_t       st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_data,
  input  size_t       ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;
  logic [31:0] ld_shift_s;

  // Store path: place the low byte/half of the store data on its lanes.
  always_comb begin
    st_data = 32'h0000_0000;
    case (st_size)
      SZ_BYTE: st_data = {24'h00_0000, st_wdata[7:0]} << {st_lane, 3'b000};
      SZ_HALF: st_data = st_lane[1] ? {st_wdata[15:0], 16'h0000}
                                    : {16'h0000, st_wdata[15:0]};
      default: st_data = st_wdata;
    endcase
  end

  // Load path: pull the addressed lane(s) down to bit 0 and extend.
  always_comb begin
    ld_shift_s = ld_word >> {ld_lane, 3'b000};
    ld_byte_s  = ld_shift_s[7:0];
    ld_half_s  = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data    = 32'h0000_0000;
    case (ld_size)
      SZ_BYTE: ld_data = ld_unsigned ? {24'h00_0000, ld_byte_s}
                                     : {{24{ld_byte_s[7]}}, ld_byte_s};
      SZ_HALF: ld_data = ld_unsigned ? {16'h0000, ld_half_s}
                                     : {{16{ld_half_s[15]}}, ld_half_s};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester round-robin arbiter/sequencer for the byte-lane data memory.
// Port 0 = core LSU, port 1 = DMA/debug. One request at a time:
// IDLE (handshake) -> ACCESS (strobe) -> RESP (response pulse) -> IDLE.
// Ports:
//   clk            system clock, posedge
//   rst            asynchronous active-low reset
//   req0, req1     requester interfaces (slave modport)
//   mrd, mwr       memory read/write strobes (ACCESS cycle only)
//   adr            word-aligned memory address
//   d_in           lane-positioned write data
//   data_out_mask  byte-lane mask
//   d_out          combinational memory read word
// Build option: DMEM_MISALIGN_TRAP_EN -- misaligned half/word accesses are
// not issued to memory and respond with rsp_err=1, rdata=0. Without it the
// address bits below the access size are ignored and rsp_err is always 0.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
)(
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave req0,
  dmem_arbiter_if.slave req1,
  output logic          mrd,
  output logic          mwr,
  output logic [AW-1:0] adr,
  output logic [DW-1:0] d_in,
  output logic [3:0]    data_out_mask,
  input  logic [DW-1:0] d_out
);

  state_t        state_r;
  logic          rr_r;       // port preferred on the next contended grant
  logic          port_r;
  logic          we_r;
  size_t         size_r;
  logic          uns_r;
  logic [1:0]    lane_r;
  logic          mis_r;
  logic          rsp0_valid_r, rsp1_valid_r;
  logic [DW-1:0] rsp0_rdata_r, rsp1_rdata_r;
  logic          rsp0_err_r,   rsp1_err_r;

  logic          grant_any_s;
  logic          grant_port_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_adr_s;
  logic [DW-1:0] sel_wdata_s;
  size_t         sel_size_s;
  logic          sel_uns_s;
  logic          sel_mis_s;
  logic [DW-1:0] st_data_s;
  logic [DW-1:0] ld_data_s;
  logic [DW-1:0] rsp_data_s;

  // Grant decision: only in IDLE; contention resolved by the rr pointer.
  always_comb begin
    grant_any_s  = 1'b0;
    grant_port_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (req0.valid && req1.valid) begin
        grant_any_s  = 1'b1;
        grant_port_s = rr_r;
      end else if (req0.valid) begin
        grant_any_s  = 1'b1;
        grant_port_s = 1'b0;
      end else if (req1.valid) begin
        grant_any_s  = 1'b1;
        grant_port_s = 1'b1;
      end else begin
        grant_any_s  = 1'b0;
        grant_port_s = 1'b0;
      end
    end else begin
      grant_any_s  = 1'b0;
      grant_port_s = 1'b0;
    end
  end

  // ready is gated by rst so nothing can handshake while reset is held.
  assign req0.ready = rst && grant_any_s && !grant_port_s;
  assign req1.ready = rst && grant_any_s &&  grant_port_s;

  assign sel_we_s    = grant_port_s ? req1.we          : req0.we;
  assign sel_adr_s   = grant_port_s ? req1.adr         : req0.adr;
  assign sel_wdata_s = grant_port_s ? req1.wdata       : req0.wdata;
  assign sel_size_s  = grant_port_s ? req1.size        : req0.size;
  assign sel_uns_s   = grant_port_s ? req1.is_unsigned : req0.is_unsigned;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign sel_mis_s = misaligned(sel_size_s, sel_adr_s[1:0]);
`else
  assign sel_mis_s = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .st_size     (sel_size_s),
    .st_lane     (sel_adr_s[1:0]),
    .st_wdata    (sel_wdata_s),
    .st_data     (st_data_s),
    .ld_size     (size_r),
    .ld_lane     (lane_r),
    .ld_unsigned (uns_r),
    .ld_word     (d_out),
    .ld_data     (ld_data_s)
  );

  // Stores and trapped accesses respond with zero data.
  assign rsp_data_s = (we_r || mis_r) ? {DW{1'b0}} : ld_data_s;

  assign req0.rsp_valid = rsp0_valid_r;
  assign req0.rsp_rdata = rsp0_rdata_r;
  assign req0.rsp_err   = rsp0_err_r;
  assign req1.rsp_valid = rsp1_valid_r;
  assign req1.rsp_rdata = rsp1_rdata_r;
  assign req1.rsp_err   = rsp1_err_r;

  // Sequencer: registers the granted request, drives strobes, emits response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      rr_r          <= 1'b0;
      port_r        <= 1'b0;
      we_r          <= 1'b0;
      size_r        <= SZ_BYTE;
      uns_r         <= 1'b0;
      lane_r        <= 2'b00;
      mis_r         <= 1'b0;
      mrd           <= 1'b0;
      mwr           <= 1'b0;
      adr           <= {AW{1'b0}};
      d_in          <= {DW{1'b0}};
      data_out_mask <= MASK_NONE;
      rsp0_valid_r  <= 1'b0;
      rsp0_rdata_r  <= {DW{1'b0}};
      rsp0_err_r    <= 1'b0;
      rsp1_valid_r  <= 1'b0;
      rsp1_rdata_r  <= {DW{1'b0}};
      rsp1_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_any_s) begin
            state_r       <= ST_ACCESS;
            // Every grant hands priority to the other port.
            rr_r          <= ~grant_port_s;
            port_r        <= grant_port_s;
            we_r          <= sel_we_s;
            size_r        <= sel_size_s;
            uns_r         <= sel_uns_s;
            lane_r        <= sel_adr_s[1:0];
            mis_r         <= sel_mis_s;
            adr           <= {sel_adr_s[AW-1:2], 2'b00};
            d_in          <= st_data_s;
            data_out_mask <= lane_mask(sel_size_s, sel_adr_s[1:0]);
            mrd           <= !sel_we_s && !sel_mis_s;
            mwr           <=  sel_we_s && !sel_mis_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_r <= ST_RESP;
          mrd     <= 1'b0;
          mwr     <= 1'b0;
          if (port_r) begin
            rsp1_valid_r <= 1'b1;
            rsp1_rdata_r <= rsp_data_s;
            rsp1_err_r   <= mis_r;
          end else begin
            rsp0_valid_r <= 1'b1;
            rsp0_rdata_r <= rsp_data_s;
            rsp0_err_r   <= mis_r;
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          rsp0_valid_r <= 1'b0;
          rsp0_rdata_r <= {DW{1'b0}};
          rsp0_err_r   <= 1'b0;
          rsp1_valid_r <= 1'b0;
          rsp1_rdata_r <= {DW{1'b0}};
          rsp1_err_r   <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          mrd          <= 1'b0;
          mwr          <= 1'b0;
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A byte-addressed reference memory
// (0x1000..0x103F) predicts every response; a word memory model answers the
// DUT's strobes. Directed scenarios first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mrd, mwr;
  logic [31:0] adr, d_in, d_out;
  logic [3:0]  mask;

  dmem_arbiter_if r0 ();
  dmem_arbiter_if r1 ();

  dmem_arbiter dut (
    .clk(clk), .rst(rst), .req0(r0), .req1(r1),
    .mrd(mrd), .mwr(mwr), .adr(adr), .d_in(d_in),
    .data_out_mask(mask), .d_out(d_out)
  );

  // Clock generator.
  always #5 clk = ~clk;

  logic [31:0] init_vals [0:15];
  logic        init_mem = 1'b0;
  logic [31:0] env_mem  [0:15];
  logic [7:0]  ref_mem  [0:63];

  assign d_out = env_mem[adr[5:2]];

  // Memory model: loads initial contents, then honours masked writes.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_vals[i];
    end else if (mwr) begin
      for (int i = 0; i < 4; i++)
        if (mask[i]) env_mem[adr[5:2]][8*i +: 8] <= d_in[8*i +: 8];
    end
  end

  int checks   = 0;
  int failures = 0;
  int exp_rr   = 0;

  logic        v_valid [2];
  logic        v_we    [2];
  logic [31:0] v_adr   [2];
  logic [31:0] v_wdata [2];
  logic [1:0]  v_size  [2];
  logic        v_uns   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push();
    r0.valid = v_valid[0]; r0.we = v_we[0]; r0.adr = v_adr[0]; r0.wdata = v_wdata[0];
    r0.size = v_size[0]; r0.is_unsigned = v_uns[0];
    r1.valid = v_valid[1]; r1.we = v_we[1]; r1.adr = v_adr[1]; r1.wdata = v_wdata[1];
    r1.size = v_size[1]; r1.is_unsigned = v_uns[1];
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic uns);
    v_valid[p] = 1'b1; v_we[p] = we; v_adr[p] = a; v_wdata[p] = wd;
    v_size[p] = sz; v_uns[p] = uns;
  endtask

  task automatic rand_req(input int p);
    set_req(p, 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 63)),
            $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endtask

  // One full transaction, entered at a negedge with the DUT idle.
  task automatic do_txn(output int gport, output logic [31:0] got_rdata, output logic got_err);
    int          p, n, ea, cnt;
    logic [31:0] a, wd, exp_din, exp_rd, ones;
    logic [3:0]  exp_mask;
    logic        we, uns, mis;
    if (v_valid[0] && v_valid[1]) p = exp_rr;
    else if (v_valid[1])          p = 1;
    else                          p = 0;
    push();
    #1;
    cnt = 0;
    while (!(r0.ready || r1.ready) && cnt < 8) begin
      @(negedge clk); #1; cnt++;
    end
    chk("grant", {30'h0, r1.ready, r0.ready}, (p == 1) ? 32'h2 : 32'h1);
    a = v_adr[p]; wd = v_wdata[p]; we = v_we[p]; uns = v_uns[p];
    n = (v_size[p] == 2'b00) ? 1 : (v_size[p] == 2'b01) ? 2 : 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (int'(a) % n) != 0;
`else
    mis = 1'b0;
`endif
    ea       = int'(a) - (int'(a) % n);
    exp_mask = 4'(((32'd1 << n) - 32'd1) << (ea % 4));
    exp_din  = 32'h0;
    exp_rd   = 32'h0;
    ones     = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) exp_din[8*((ea % 4) + i) +: 8] = wd[8*i +: 8];
    if (!we && !mis) begin
      for (int i = 0; i < n; i++) exp_rd = exp_rd | (32'(ref_mem[ea - 32'h1000 + i]) << (8*i));
      if (!uns && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | (ones << (8*n));
    end
    if (we && !mis)
      for (int i = 0; i < n; i++) ref_mem[ea - 32'h1000 + i] = wd[8*i +: 8];
    exp_rr = 1 - p;
    gport  = p;
    @(posedge clk);
    @(negedge clk);
    v_valid[p] = 1'b0;
    push();
    chk("acc_mrd",  {31'h0, mrd}, {31'h0, !we && !mis});
    chk("acc_mwr",  {31'h0, mwr}, {31'h0, we && !mis});
    chk("acc_adr",  adr, {a[31:2], 2'b00});
    chk("acc_mask", {28'h0, mask}, {28'h0, exp_mask});
    if (we && !mis) chk("acc_din", d_in, exp_din);
    chk("acc_norsp", {30'h0, r1.rsp_valid, r0.rsp_valid}, 32'h0);
    @(negedge clk);
    chk("rsp_valid", {30'h0, r1.rsp_valid, r0.rsp_valid}, (p == 1) ? 32'h2 : 32'h1);
    got_rdata = (p == 1) ? r1.rsp_rdata : r0.rsp_rdata;
    got_err   = (p == 1) ? r1.rsp_err   : r0.rsp_err;
    chk("rsp_rdata", got_rdata, exp_rd);
    chk("rsp_err", {31'h0, got_err}, {31'h0, mis});
    chk("rsp_other_rdata", (p == 1) ? r0.rsp_rdata : r1.rsp_rdata, 32'h0);
    chk("rsp_strobes", {30'h0, mrd, mwr}, 32'h0);
    @(negedge clk);
  endtask

  // Directed and randomized stimulus.
  initial begin
    int          gp, last, cnt;
    logic [31:0] rd;
    logic        er;
    rst = 1'b0;
    for (int p = 0; p < 2; p++) set_req(p, 1'b0, 32'h1000, 32'h0, 2'b10, 1'b0);
    push();
    for (int i = 0; i < 16; i++) begin
      init_vals[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = init_vals[i][8*b +: 8];
    end
    init_mem = 1'b1;
    repeat (2) @(negedge clk);
    init_mem = 1'b0;
    #1;
    chk("rst_ready", {30'h0, r1.ready, r0.ready}, 32'h0);
    chk("rst_strobes", {30'h0, mrd, mwr}, 32'h0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_din", d_in, 32'h0);
    chk("rst_mask", {28'h0, mask}, 32'h0);
    chk("rst_rsp", {28'h0, r1.rsp_valid, r1.rsp_err, r0.rsp_valid, r0.rsp_err}, 32'h0);
    chk("rst_rdata", r0.rsp_rdata | r1.rsp_rdata, 32'h0);
    @(negedge clk);
    v_valid[0] = 1'b0; v_valid[1] = 1'b0;
    push();
    rst = 1'b1;
    exp_rr = 0;
    @(negedge clk);

    // Word store, signed byte load, half store + word readback.
    set_req(0, 1'b1, 32'h1000, 32'hDEAD_BEEF, SZ_WORD, 1'b0);
    do_txn(gp, rd, er);
    set_req(0, 1'b0, 32'h1003, 32'h0, SZ_BYTE, 1'b0);
    do_txn(gp, rd, er);
    chk("byte_signed_load", rd, 32'hFFFF_FFDE);
    set_req(0, 1'b1, 32'h1002, 32'h0000_1234, SZ_HALF, 1'b1);
    do_txn(gp, rd, er);
    set_req(0, 1'b0, 32'h1000, 32'h0, SZ_WORD, 1'b0);
    do_txn(gp, rd, er);
    chk("half_store_readback", rd, 32'h1234_BEEF);

    // Misaligned word load.
    set_req(0, 1'b0, 32'h1001, 32'h0, SZ_WORD, 1'b0);
    do_txn(gp, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("misalign_err", {31'h0, er}, 32'h1);
    chk("misalign_rdata", rd, 32'h0);
`else
    chk("misalign_err", {31'h0, er}, 32'h0);
    chk("misalign_rdata", rd, 32'h1234_BEEF);
`endif

    // Both ports hammering: grants must alternate.
    last = -1;
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 2; p++)
        if (!v_valid[p]) set_req(p, 1'b0, 32'h1000 + 32'($urandom_range(0, 63)), 32'h0, SZ_BYTE, 1'b1);
      do_txn(gp, rd, er);
      if (last >= 0) chk("alternate", 32'(gp), 32'(1 - last));
      last = gp;
    end
    v_valid[0] = 1'b0; v_valid[1] = 1'b0;

    // Randomized mixed traffic.
    for (int k = 0; k < 60; k++) begin
      for (int p = 0; p < 2; p++)
        if (!v_valid[p] && $urandom_range(0, 1) == 1) rand_req(p);
      if (!v_valid[0] && !v_valid[1]) rand_req(int'($urandom_range(0, 1)));
      do_txn(gp, rd, er);
    end
    v_valid[0] = 1'b0; v_valid[1] = 1'b0;
    push();

    // Reset during the ACCESS cycle of a store.
    set_req(0, 1'b1, 32'h1020, 32'hA5A5_A5A5, SZ_WORD, 1'b0);
    push();
    #1;
    cnt = 0;
    while (!r0.ready && cnt < 8) begin
      @(negedge clk); #1; cnt++;
    end
    chk("abort_grant", {31'h0, r0.ready}, 32'h1);
    @(posedge clk);
    #2;
    chk("abort_mwr_before", {31'h0, mwr}, 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_strobes", {30'h0, mrd, mwr}, 32'h0);
    v_valid[0] = 1'b0;
    push();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("abort_norsp", {30'h0, r1.rsp_valid, r0.rsp_valid}, 32'h0);
    end
    rst = 1'b1;
    exp_rr = 0;
    @(negedge clk);
    chk("abort_norsp_after", {30'h0, r1.rsp_valid, r0.rsp_valid}, 32'h0);
    set_req(1, 1'b0, 32'h1020, 32'h0, SZ_WORD, 1'b0);
    do_txn(gp, rd, er);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
